// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types: memory arbiter states, requester ids and grant encoding.
package pdp8_pkg;

  localparam int ARB_STARVE_MAX_DEFAULT = 4;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} arb_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_IFU, SRC_EXRD, SRC_EXWR} arb_src_t;

  // One-hot grant bit positions from the priority picker
  localparam logic [2:0] GNT_IFU  = 3'b001;
  localparam logic [2:0] GNT_EXRD = 3'b010;
  localparam logic [2:0] GNT_EXWR = 3'b100;

  function automatic arb_src_t grant_to_src(input logic [2:0] g);
    arb_src_t s;
    case (g)
      GNT_IFU:  s = SRC_IFU;
      GNT_EXRD: s = SRC_EXRD;
      GNT_EXWR: s = SRC_EXWR;
      default:  s = SRC_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pdp8_arb_pri.sv
// Fixed-priority picker (EU write > EU read > IFU) with an IFU starvation override.
module pdp8_arb_pri
  import pdp8_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_arb_en,
  input  logic       i_ifu_req,
  input  logic       i_exrd_req,
  input  logic       i_exwr_req,
  output logic [2:0] o_grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_starved;

  assign w_starved = (r_starve_cnt == STARVE_LIM);

  always_comb begin
    o_grant = 3'b000;
    if (i_arb_en) begin
      if (w_starved && i_ifu_req) o_grant = GNT_IFU;
      else if (i_exwr_req)        o_grant = GNT_EXWR;
      else if (i_exrd_req)        o_grant = GNT_EXRD;
      else if (i_ifu_req)         o_grant = GNT_IFU;
    end
  end

  // Counts EU grants that bypassed a waiting fetch; any IFU grant or idle IFU clears it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (|o_grant) begin
      if (o_grant[0] || !i_ifu_req) r_starve_cnt <= '0;
      else if (!w_starved)          r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Shares the PDP-8 memory port between IFU fetches and EU reads/writes,
// one transaction in flight, registered acks and data.
module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MEM_RD_LAT = 1,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  output logic                  ifu_stall,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_ack,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  arb_state_t r_state, w_state_nxt;
  arb_src_t   r_src, w_src;
  logic [2:0] r_lat_cnt;
  logic [2:0] w_grant;
  logic       w_lat_done;

  assign w_lat_done = (r_lat_cnt == 3'(MEM_RD_LAT));
  assign w_src      = grant_to_src(w_grant);
  assign ifu_stall  = ifu_rd_req & ~ifu_rd_ack;

  pdp8_arb_pri #(.STARVE_MAX(STARVE_MAX)) u_pri (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_arb_en   (r_state == IDLE),
    .i_ifu_req  (ifu_rd_req),
    .i_exrd_req (exec_rd_req),
    .i_exwr_req (exec_wr_req),
    .o_grant    (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_src == SRC_EXWR)      w_state_nxt = WR_ISSUE;
                else if (w_src != SRC_NONE) w_state_nxt = RD_ISSUE;
      RD_ISSUE: w_state_nxt = RD_WAIT;
      RD_WAIT:  if (w_lat_done) w_state_nxt = RESP;
      WR_ISSUE: w_state_nxt = RESP;
      RESP:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_src        <= SRC_NONE;
      r_lat_cnt    <= '0;
      busy         <= 1'b0;
      mem_rd_req   <= 1'b0;
      mem_wr_req   <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      ifu_rd_ack   <= 1'b0;
      exec_rd_ack  <= 1'b0;
      exec_wr_ack  <= 1'b0;
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      busy        <= (w_state_nxt != IDLE);
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      ifu_rd_ack  <= 1'b0;
      exec_rd_ack <= 1'b0;
      exec_wr_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_src <= w_src;
          case (w_src)
            SRC_EXWR: begin
              mem_addr    <= exec_wr_addr;
              mem_wr_data <= exec_wr_data;
              mem_wr_req  <= 1'b1;
            end
            SRC_EXRD: begin
              mem_addr   <= exec_rd_addr;
              mem_rd_req <= 1'b1;
            end
            SRC_IFU: begin
              mem_addr   <= ifu_rd_addr;
              mem_rd_req <= 1'b1;
            end
            default: ;
          endcase
        end
        RD_ISSUE: r_lat_cnt <= 3'd1;
        RD_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 3'd1;
          if (w_lat_done) begin
            if (r_src == SRC_IFU) begin
              ifu_rd_data <= mem_rd_data;
              ifu_rd_ack  <= 1'b1;
            end else begin
              exec_rd_data <= mem_rd_data;
              exec_rd_ack  <= 1'b1;
            end
          end
        end
        WR_ISSUE: exec_wr_ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_pdp8_mem_arbiter;
  import pdp8_pkg::*;

  localparam logic [11:0] JUNK = 12'o5252;

  typedef struct {
    arb_src_t    src;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Instance A: default latency 1
  logic        a_reset_n, a_ifu_rd_req, a_ifu_rd_ack, a_ifu_stall;
  logic        a_exec_rd_req, a_exec_rd_ack, a_exec_wr_req, a_exec_wr_ack;
  logic        a_mem_rd_req, a_mem_wr_req, a_busy;
  logic [11:0] a_ifu_rd_addr, a_ifu_rd_data, a_exec_rd_addr, a_exec_rd_data;
  logic [11:0] a_exec_wr_addr, a_exec_wr_data, a_mem_addr, a_mem_wr_data, a_mem_rd_data;

  // Instance B: latency 3
  logic        b_reset_n, b_ifu_rd_req, b_ifu_rd_ack, b_ifu_stall;
  logic        b_exec_rd_req, b_exec_rd_ack, b_exec_wr_req, b_exec_wr_ack;
  logic        b_mem_rd_req, b_mem_wr_req, b_busy;
  logic [11:0] b_ifu_rd_addr, b_ifu_rd_data, b_exec_rd_addr, b_exec_rd_data;
  logic [11:0] b_exec_wr_addr, b_exec_wr_data, b_mem_addr, b_mem_wr_data, b_mem_rd_data;

  pdp8_mem_arbiter u_dut (
    .clk(clk), .reset_n(a_reset_n),
    .ifu_rd_req(a_ifu_rd_req), .ifu_rd_addr(a_ifu_rd_addr), .ifu_rd_data(a_ifu_rd_data),
    .ifu_rd_ack(a_ifu_rd_ack), .ifu_stall(a_ifu_stall),
    .exec_rd_req(a_exec_rd_req), .exec_rd_addr(a_exec_rd_addr), .exec_rd_data(a_exec_rd_data),
    .exec_rd_ack(a_exec_rd_ack),
    .exec_wr_req(a_exec_wr_req), .exec_wr_addr(a_exec_wr_addr), .exec_wr_data(a_exec_wr_data),
    .exec_wr_ack(a_exec_wr_ack),
    .mem_rd_req(a_mem_rd_req), .mem_wr_req(a_mem_wr_req), .mem_addr(a_mem_addr),
    .mem_wr_data(a_mem_wr_data), .mem_rd_data(a_mem_rd_data), .busy(a_busy)
  );

  pdp8_mem_arbiter #(.MEM_RD_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(b_reset_n),
    .ifu_rd_req(b_ifu_rd_req), .ifu_rd_addr(b_ifu_rd_addr), .ifu_rd_data(b_ifu_rd_data),
    .ifu_rd_ack(b_ifu_rd_ack), .ifu_stall(b_ifu_stall),
    .exec_rd_req(b_exec_rd_req), .exec_rd_addr(b_exec_rd_addr), .exec_rd_data(b_exec_rd_data),
    .exec_rd_ack(b_exec_rd_ack),
    .exec_wr_req(b_exec_wr_req), .exec_wr_addr(b_exec_wr_addr), .exec_wr_data(b_exec_wr_data),
    .exec_wr_ack(b_exec_wr_ack),
    .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req), .mem_addr(b_mem_addr),
    .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data), .busy(b_busy)
  );

  // Memory models: data is driven only in the cycle it is due, junk otherwise
  logic [11:0] mem_a [0:4095];
  logic [11:0] mem_b [0:4095];
  logic        pl_a_en = 1'b0, pl_b_en = 1'b0;
  logic [11:0] pl_addr = '0, pl_data = '0;
  logic        a_pv = 1'b0;
  logic [11:0] a_pa = '0;
  logic [2:0]  b_pv = '0;
  logic [11:0] b_pa [3];

  always @(posedge clk) begin
    if (pl_a_en) mem_a[pl_addr] <= pl_data;
    if (pl_b_en) mem_b[pl_addr] <= pl_data;
    if (a_mem_wr_req) mem_a[a_mem_addr] <= a_mem_wr_data;
    if (b_mem_wr_req) mem_b[b_mem_addr] <= b_mem_wr_data;
    a_pv    <= a_mem_rd_req;
    a_pa    <= a_mem_addr;
    b_pv    <= {b_pv[1:0], b_mem_rd_req};
    b_pa[0] <= b_mem_addr;
    b_pa[1] <= b_pa[0];
    b_pa[2] <= b_pa[1];
  end

  assign a_mem_rd_data = a_pv    ? mem_a[a_pa]    : JUNK;
  assign b_mem_rd_data = b_pv[2] ? mem_b[b_pa[2]] : JUNK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit b, input arb_src_t s, input logic [11:0] d, input int c);
    exp_t e;
    e.src = s; e.data = d; e.cyc = c;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic mon_check(input bit b, input arb_src_t s, input logic [11:0] d);
    exp_t e;
    n_cmp++;
    if ((b && qb.size() == 0) || (!b && qa.size() == 0)) begin
      n_err++;
      $display("FAIL ack_unexpected inst=%0d: got src=%0d data=%o cyc=%0d, required no ack",
               b, s, d, cyc);
      return;
    end
    if (b) e = qb.pop_front();
    else   e = qa.pop_front();
    if (e.src != s || (s != SRC_EXWR && e.data != d) || e.cyc != cyc) begin
      n_err++;
      $display("FAIL ack inst=%0d: got src=%0d data=%o cyc=%0d, required src=%0d data=%o cyc=%0d",
               b, s, d, cyc, e.src, e.data, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_ifu_rd_ack)  mon_check(1'b0, SRC_IFU,  a_ifu_rd_data);
    if (a_exec_rd_ack) mon_check(1'b0, SRC_EXRD, a_exec_rd_data);
    if (a_exec_wr_ack) mon_check(1'b0, SRC_EXWR, 12'o0);
    if (b_ifu_rd_ack)  mon_check(1'b1, SRC_IFU,  b_ifu_rd_data);
    if (b_exec_rd_ack) mon_check(1'b1, SRC_EXRD, b_exec_rd_data);
    if (b_exec_wr_ack) mon_check(1'b1, SRC_EXWR, 12'o0);
  end

  function automatic logic sel_ack(input int which);
    case (which)
      0:       return a_ifu_rd_ack;
      1:       return a_exec_rd_ack;
      2:       return a_exec_wr_ack;
      default: return b_exec_rd_ack;
    endcase
  endfunction

  task automatic wait_ack(input int which);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sel_ack(which)) break;
    end
    if (!sel_ack(which)) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout requester=%0d: got no ack in 100 cycles, required ack", which);
    end
  endtask

  task automatic a_ifu(input logic [11:0] ad);
    a_ifu_rd_addr = ad; a_ifu_rd_req = 1'b1;
    wait_ack(0);
    a_ifu_rd_req = 1'b0;
  endtask

  task automatic a_exrd(input logic [11:0] ad);
    a_exec_rd_addr = ad; a_exec_rd_req = 1'b1;
    wait_ack(1);
    a_exec_rd_req = 1'b0;
  endtask

  task automatic a_exwr(input logic [11:0] ad, input logic [11:0] d);
    a_exec_wr_addr = ad; a_exec_wr_data = d; a_exec_wr_req = 1'b1;
    wait_ack(2);
    a_exec_wr_req = 1'b0;
  endtask

  task automatic b_exrd(input logic [11:0] ad);
    b_exec_rd_addr = ad; b_exec_rd_req = 1'b1;
    wait_ack(3);
    b_exec_rd_req = 1'b0;
  endtask

  task automatic preload(input bit b, input logic [11:0] ad, input logic [11:0] d);
    pl_addr = ad; pl_data = d;
    if (b) pl_b_en = 1'b1;
    else   pl_a_en = 1'b1;
    @(negedge clk);
    pl_a_en = 1'b0; pl_b_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, t;
    logic [11:0] ra, rd;
    a_reset_n = 1'b0; b_reset_n = 1'b0;
    a_ifu_rd_req = 0; a_exec_rd_req = 0; a_exec_wr_req = 0;
    a_ifu_rd_addr = '0; a_exec_rd_addr = '0; a_exec_wr_addr = '0; a_exec_wr_data = '0;
    b_ifu_rd_req = 0; b_exec_rd_req = 0; b_exec_wr_req = 0;
    b_ifu_rd_addr = '0; b_exec_rd_addr = '0; b_exec_wr_addr = '0; b_exec_wr_data = '0;
    repeat (2) @(negedge clk);

    preload(0, 12'o0200, 12'o7300);
    preload(0, 12'o0100, 12'o4321);
    preload(0, 12'o0040, 12'o0000);
    preload(0, 12'o0300, 12'o6001);
    preload(0, 12'o0301, 12'o6002);
    preload(0, 12'o0400, 12'o1111);
    for (int k = 0; k < 10; k++) preload(0, 12'o1000 + 12'(k), 12'o2000 + 12'(k));
    b_reset_n = 1'b1;

    // Reset held 3 cycles with every request high; write must win afterwards
    g = cyc + 3;
    push(0, SRC_EXWR, 12'o0,    g + 2);
    push(0, SRC_EXRD, 12'o4321, g + 6);
    push(0, SRC_IFU,  12'o7300, g + 10);
    fork
      a_exwr(12'o0500, 12'o0777);
      a_exrd(12'o0100);
      a_ifu(12'o0200);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("reset_ctl", {a_ifu_rd_ack, a_exec_rd_ack, a_exec_wr_ack,
                            a_mem_rd_req, a_mem_wr_req, a_busy}, 64'h0);
          chk("reset_data", {a_ifu_rd_data, a_exec_rd_data, a_mem_addr, a_mem_wr_data}, 64'h0);
        end
        a_reset_n = 1'b1;
      end
    join

    // Single fetch: strobe and stall timing
    @(negedge clk);
    push(0, SRC_IFU, 12'o7300, cyc + 3);
    fork
      a_ifu(12'o0200);
      begin
        #1;
        chk("stall_c0", a_ifu_stall, 1);
        chk("rdreq_c0", {a_mem_rd_req, a_busy}, 0);
        @(negedge clk);
        chk("rdreq_c1", {a_mem_rd_req, a_mem_addr}, {1'b1, 12'o0200});
        chk("stall_c1", {a_ifu_stall, a_busy}, 2'b11);
        @(negedge clk);
        chk("rdreq_c2", a_mem_rd_req, 0);
        chk("stall_c2", a_ifu_stall, 1);
        @(negedge clk);
        chk("stall_c3", a_ifu_stall, 0);
      end
    join

    // Write and read to the same word in the same cycle: write first
    @(negedge clk);
    push(0, SRC_EXWR, 12'o0,    cyc + 2);
    push(0, SRC_EXRD, 12'o1234, cyc + 6);
    fork
      a_exwr(12'o0040, 12'o1234);
      a_exrd(12'o0040);
      begin
        @(negedge clk);
        chk("wrstrobe_c1", {a_mem_wr_req, a_mem_rd_req, a_mem_addr, a_mem_wr_data},
            {1'b1, 1'b0, 12'o0040, 12'o1234});
      end
    join

    // Starvation: IFU waits out 4 EU grants, twice; counter must restart after each fetch
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 4; k++) push(0, SRC_EXRD, 12'o2000 + 12'(k), t + 3 + 4*k);
    push(0, SRC_IFU, 12'o6001, t + 19);
    for (int k = 4; k < 8; k++) push(0, SRC_EXRD, 12'o2000 + 12'(k), t + 23 + 4*(k-4));
    push(0, SRC_IFU, 12'o6002, t + 39);
    push(0, SRC_EXRD, 12'o2010, t + 43);
    push(0, SRC_EXRD, 12'o2011, t + 47);
    fork
      for (int k = 0; k < 10; k++) a_exrd(12'o1000 + 12'(k));
      begin a_ifu(12'o0300); a_ifu(12'o0301); end
    join

    // Reset during RD_WAIT of a fetch: no ack, then a clean fetch
    @(negedge clk);
    a_ifu_rd_addr = 12'o0400; a_ifu_rd_req = 1'b1;
    repeat (2) @(negedge clk);
    a_reset_n = 1'b0; a_ifu_rd_req = 1'b0;
    @(negedge clk);
    chk("midrst_c1", {a_ifu_rd_ack, a_ifu_rd_data, a_busy}, 0);
    @(negedge clk);
    chk("midrst_c2", {a_ifu_rd_ack, a_mem_rd_req}, 0);
    a_reset_n = 1'b1;
    preload(0, 12'o0400, 12'o2222);
    push(0, SRC_IFU, 12'o2222, cyc + 3);
    a_ifu(12'o0400);

    // Latency sweep on the 3-cycle instance
    for (int i = 0; i < 16; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rd = 12'($urandom_range(1, 4095));
      preload(1, ra, rd);
      push(1, SRC_EXRD, rd, cyc + 5);
      b_exrd(ra);
    end

    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("b_quiet", {b_busy, b_ifu_stall, b_mem_wr_req, b_mem_wr_data}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
- Shares the single PDP-8 main-memory port between the instruction fetch unit (IFU reads) and the execution unit (operand reads and writes).
- Sits between the IFU/EU and the memory model or stim memory.
- Serialises requests with fixed priority and bounded starvation, allowing one outstanding transaction at a time.
- Returns read data with a single-cycle ack pulse and drives an IFU stall while a fetch is pending.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (12), memory address width.
- DATA_WIDTH, `DATA_WIDTH (12), memory word width.
- MEM_RD_LAT, 1, cycles from the cycle mem_rd_req is high to the cycle mem_rd_data is valid (legal range 1..7).
- STARVE_MAX, 4, consecutive EU grants made while ifu_rd_req is pending before the IFU is forced top priority (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- ifu_rd_req  in  1  IFU fetch request; level signal, held until ifu_rd_ack.
- ifu_rd_addr  in  ADDR_WIDTH  fetch address; stable while ifu_rd_req is high.
- ifu_rd_data  out  DATA_WIDTH  fetched word; valid only when ifu_rd_ack is high.
- ifu_rd_ack  out  1  one-cycle completion pulse for a fetch.
- ifu_stall  out  1  high while ifu_rd_req is pending and not completing this cycle.
- exec_rd_req  in  1  EU read request; level, held until exec_rd_ack.
- exec_rd_addr  in  ADDR_WIDTH  EU read address.
- exec_rd_data  out  DATA_WIDTH  EU read word; valid only when exec_rd_ack is high.
- exec_rd_ack  out  1  one-cycle completion pulse for an EU read.
- exec_wr_req  in  1  EU write request; level, held until exec_wr_ack.
- exec_wr_addr  in  ADDR_WIDTH  EU write address.
- exec_wr_data  in  DATA_WIDTH  EU write word.
- exec_wr_ack  out  1  one-cycle completion pulse for an EU write.
- mem_rd_req  out  1  memory read strobe, one cycle per read.
- mem_wr_req  out  1  memory write strobe, one cycle per write.
- mem_addr  out  ADDR_WIDTH  memory address; valid with either strobe.
- mem_wr_data  out  DATA_WIDTH  memory write data; valid with mem_wr_req.
- mem_rd_data  in  DATA_WIDTH  memory read data, returned per MEM_RD_LAT.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered except ifu_stall, which is combinational from ifu_rd_req and state.
- Reset when reset_n is low at a clk edge:
  - state becomes IDLE; starve_cnt and lat_cnt become 0.
  - All strobes, acks and busy are 0; ifu_rd_data, exec_rd_data, mem_addr and mem_wr_data are 0.
  - A transaction in flight is abandoned: no ack is issued, and late mem_rd_data is ignored.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE: arbitrate among requests high this cycle.
  - Priority when starve_cnt < STARVE_MAX: exec_wr > exec_rd > ifu_rd.
  - When starve_cnt == STARVE_MAX: ifu_rd > exec_wr > exec_rd.
  - On the edge: latch winner id, mem_addr and write data, then go to RD_ISSUE or WR_ISSUE.
  - No request pending: stay in IDLE.
- RD_ISSUE: mem_rd_req=1 for exactly one cycle; lat_cnt=1; go to RD_WAIT.
- RD_WAIT: increment lat_cnt each cycle.
  - On the cycle lat_cnt == MEM_RD_LAT (MEM_RD_LAT cycles after RD_ISSUE), sample mem_rd_data into the winner's data register.
  - Then go to RESP.
- WR_ISSUE: mem_wr_req=1 and mem_wr_data valid for one cycle; go to RESP.
- RESP: the winner's ack is 1 for exactly one cycle; next state is IDLE unconditionally.
  - Requests are not sampled in RESP, so a requester that drops req after seeing ack is never double-served.
- Latency from a req first seen in IDLE to ack:
  - Read: 2+MEM_RD_LAT cycles (3 at default).
  - Write: 2 cycles.
- Throughput: back-to-back same-requester transactions are spaced by one IDLE cycle.
- Starvation counter:
  - On each EU grant with ifu_rd_req high, starve_cnt increments, saturating at STARVE_MAX.
  - On an IFU grant, starve_cnt clears to 0.
  - On an EU grant with ifu_rd_req low, starve_cnt clears to 0.
- ifu_stall = ifu_rd_req & ~ifu_rd_ack.
- Read data registers hold their last value outside ack cycles.
  - Checkers must qualify data with ack.
  - Data never changes except on a sampling cycle.
- Requests arriving while busy wait in their requesters; there is no queue inside the block.
- A requester changing address while its req is pending, before grant, is legal; the value present in the granting IDLE cycle is used.
- Simultaneous exec_rd_req and exec_wr_req: write is served first, then read (read-after-write ordering).

Decomposition:
- Add to pdp8_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP}.
  - typedef enum logic [1:0] arb_src_t {SRC_NONE, SRC_IFU, SRC_EXRD, SRC_EXWR}.
  - Constant ARB_STARVE_MAX_DEFAULT = 4.
- One sub-module: pdp8_arb_pri, a combinational priority picker plus starvation counter, producing a one-hot grant.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 for 3 cycles with all reqs high.
  - Required: all acks, strobes and busy are 0; after release, the first grant is exec_wr.
- Single fetch:
  - Stimulus: ifu_rd_req with addr 12'o200; memory returns 12'o7300.
  - Required: mem_rd_req one cycle after req; ifu_rd_ack on cycle 3 with data 12'o7300; ifu_stall high on cycles 0-2 and low on cycle 3.
- Write then read:
  - Stimulus: exec_wr (addr 12'o0040, data 12'o1234) and exec_rd (addr 12'o0040) both raised in the same cycle.
  - Required: mem_wr_req first, exec_wr_ack at cycle 2; then exec_rd_ack with data 12'o1234.
- Starvation:
  - Stimulus: ifu_rd_req held continuously while the EU issues 6 back-to-back reads.
  - Required: the IFU is granted immediately after the 4th EU grant, and starve_cnt returns to 0.
- Reset mid-read:
  - Stimulus: assert reset_n=0 during RD_WAIT of a fetch.
  - Required: no ifu_rd_ack; the next fetch after reset completes normally with fresh data.
- Latency sweep:
  - Stimulus: MEM_RD_LAT=3, 16 random reads with random data.
  - Required: every ack arrives 5 cycles after grant with data equal to the memory model value.
